log_request_arbiter: RTL

Shares the single machine-log writer (`saveMachineLogs`) between three requesters: purchase, refill and audit. It selects one pending log command per cycle with round-robin arbitration. Accepted commands are buffered in a small FIFO and presented to the log writer through a valid/ready handshake. The block sits between the vending controller sub-units and the log writer and is the only driver of the writer's `operator`/`param*` inputs.

---
 rtl/log_request_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/log_request_arbiter.sv
// Round-robin arbiter sharing the machine-log writer between purchase, refill and audit
// requesters, with a show-ahead FIFO feeding the writer through a valid/ready handshake.
module log_request_arbiter #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [2:0]            req_valid,
  output logic [2:0]            req_ready,
  input  logic [5:0]            req_operator,
  input  logic [2:0]            req_param1,
  input  logic [11:0]           req_param2,
  input  logic [11:0]           req_param3,
  input  logic [11:0]           req_param4,
  output logic                  log_valid,
  input  logic                  log_ready,
  output logic [1:0]            operator,
  output logic                  param1,
  output logic [3:0]            param2,
  output logic [3:0]            param3,
  output logic [3:0]            param4,
  output logic [DEPTH_LOG2:0]   fifo_count,
  output logic [1:0]            last_grant
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

  logic [14:0]           mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic [1:0]            last_grant_reg;

  logic [14:0] req_entry [3];
  logic [14:0] head;
  logic [1:0]  grant_idx;
  logic [1:0]  cand;
  logic        found;
  logic        grant_en;
  logic        push;
  logic        pop;

  for (genvar gi = 0; gi < 3; gi++) begin : g_entry
    assign req_entry[gi] = {req_operator[2*gi+1:2*gi], req_param1[gi],
                            req_param2[4*gi+3:4*gi], req_param3[4*gi+3:4*gi],
                            req_param4[4*gi+3:4*gi]};
  end

  function automatic logic [1:0] rr_next(input logic [1:0] cur);
    return (cur >= 2'd2) ? 2'd0 : cur + 2'd1;
  endfunction

  // Full check uses only the registered count, so a same-cycle pop never frees a slot.
  assign grant_en = (count_reg != FULL_COUNT);

  always_comb begin
    req_ready = '0;
    grant_idx = 2'd0;
    found     = 1'b0;
    cand      = rr_next(last_grant_reg);
    for (int k = 0; k < 3; k++) begin
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
      cand = rr_next(cand);
    end
    if (found && grant_en && reset_n) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  assign push      = |req_ready;
  assign log_valid = (count_reg != '0);
  assign pop       = log_valid & log_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      last_grant_reg <= 2'd2;
    end else begin
      if (push) begin
        wr_ptr_reg     <= wr_ptr_reg + 1'b1;
        last_grant_reg <= grant_idx;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Storage carries no reset; validity is tracked entirely by count_reg.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= req_entry[grant_idx];
    end
  end

  assign head = log_valid ? mem[rd_ptr_reg] : '0;
  assign {operator, param1, param2, param3, param4} = head;
  assign fifo_count = count_reg;
  assign last_grant = last_grant_reg;

endmodule
